recon_luma16x16: RTL

- Decoder-side counterpart of the luma 16x16 intra mode predictor.
- Takes a chosen mode (V/H/DC) plus neighbour pixels and regenerates the prediction internally.
- Accepts the 16x16 residual one row per handshake, adds it to the prediction, clips the result and streams out reconstructed rows.
- Captures the bottom row and right column as neighbours for the next macroblock. Sits between the inverse transform and the frame/neighbour store.

---
 rtl/recon_luma16x16.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/recon_luma16x16.sv
// recon_luma16x16
// Decoder-side luma 16x16 intra reconstruction. Regenerates the V/H/DC
// prediction from latched neighbours, adds one residual row per handshake,
// clips to the pixel range and streams reconstructed rows downstream. The
// bottom row and right column of each finished block are published as the
// neighbours for the next macroblock.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   start, mode              block start pulse, 0=V 1=H 2=DC 3=plane(illegal)
//   top_avail, left_avail    neighbour availability
//   toppixels, leftpixels    16 neighbour pixels each, pixel i at [i*PIXW +: PIXW]
//   res_valid/res_ready      residual row handshake, res_row = 16 signed samples
//   rec_valid/rec_ready      reconstructed row handshake, rec_row/rec_idx/rec_last
//   busy, done, err          status: block in flight, completion pulse, illegal start
//   new_top, new_left        row 15 / column 15 of the last completed block
module recon_luma16x16 #(
    parameter int PIXW = 8,
    parameter int RESW = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               top_avail,
    input  logic               left_avail,
    input  logic [16*PIXW-1:0] toppixels,
    input  logic [16*PIXW-1:0] leftpixels,
    input  logic               res_valid,
    output logic               res_ready,
    input  logic [16*RESW-1:0] res_row,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [16*PIXW-1:0] rec_row,
    output logic [3:0]         rec_idx,
    output logic               rec_last,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [16*PIXW-1:0] new_top,
    output logic [16*PIXW-1:0] new_left
);

    // Sum of pred (unsigned) and residual (signed) needs one bit above the wider operand.
    localparam int SW   = ((PIXW + 1 > RESW) ? PIXW + 1 : RESW) + 1;
    localparam int ACCW = PIXW + 5;

    typedef enum logic [1:0] {IDLE, DCCALC, RUN, FLUSH} state_t;

    state_t            state_reg, state_next;
    logic [1:0]        mode_reg;
    logic              top_av_reg, left_av_reg;
    logic [PIXW-1:0]   top_reg    [16];
    logic [PIXW-1:0]   left_reg   [16];
    logic [PIXW-1:0]   shadow_reg [16];
    logic [PIXW-1:0]   dc_reg, dc_next;
    logic [3:0]        row_reg;
    logic              start_ok, start_bad;
    logic              res_fire, rec_fire;
    logic [16*PIXW-1:0] rec_pix;
    logic [ACCW-1:0]   sum_top, sum_left;

    assign res_ready = (state_reg == RUN) & (~rec_valid | rec_ready);
    assign res_fire  = res_valid & res_ready;
    assign rec_fire  = rec_valid & rec_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start_bad  = 1'b0;
        start_ok   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    start_bad = (mode == 2'd3) || (mode == 2'd0 && !top_avail) ||
                                (mode == 2'd1 && !left_avail);
                    start_ok  = !start_bad;
                end
                if (start_ok) state_next = (mode == 2'd2) ? DCCALC : RUN;
            end
            DCCALC: state_next = RUN;
            RUN:    if (res_fire && row_reg == 4'd15) state_next = FLUSH;
            FLUSH:  if (rec_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // DC value from the latched neighbours; used only during DCCALC.
    always_comb begin
        sum_top  = '0;
        sum_left = '0;
        for (int i = 0; i < 16; i++) begin
            sum_top  = sum_top  + ACCW'(top_reg[i]);
            sum_left = sum_left + ACCW'(left_reg[i]);
        end
        case ({top_av_reg, left_av_reg})
            2'b11:   dc_next = PIXW'((sum_top + sum_left + ACCW'(16)) >> 5);
            2'b10:   dc_next = PIXW'((sum_top + ACCW'(8)) >> 4);
            2'b01:   dc_next = PIXW'((sum_left + ACCW'(8)) >> 4);
            default: dc_next = PIXW'(1 << (PIXW - 1));
        endcase
    end

    // Per-column prediction, residual add and clip.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_col
            logic [PIXW-1:0]        pred;
            logic [RESW-1:0]        res;
            logic signed [SW-1:0]   sum;
            logic [PIXW-1:0]        clip;
            assign res = res_row[gi*RESW +: RESW];
            always_comb begin
                case (mode_reg)
                    2'd0:    pred = top_reg[gi];
                    2'd1:    pred = left_reg[row_reg];
                    default: pred = dc_reg;
                endcase
                sum = $signed({{(SW-PIXW){1'b0}}, pred}) +
                      $signed({{(SW-RESW){res[RESW-1]}}, res});
                if (sum[SW-1])                 clip = '0;
                else if (sum[SW-2:PIXW] != '0) clip = '1;
                else                           clip = sum[PIXW-1:0];
            end
            assign rec_pix[gi*PIXW +: PIXW] = clip;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg    <= '0;
            top_av_reg  <= 1'b0;
            left_av_reg <= 1'b0;
            dc_reg      <= '0;
            row_reg     <= '0;
            rec_valid   <= 1'b0;
            rec_row     <= '0;
            rec_idx     <= '0;
            rec_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            new_top     <= '0;
            new_left    <= '0;
            for (int i = 0; i < 16; i++) begin
                top_reg[i]    <= '0;
                left_reg[i]   <= '0;
                shadow_reg[i] <= '0;
            end
        end else begin
            err  <= start_bad;
            done <= 1'b0;
            if (start_ok) begin
                mode_reg    <= mode;
                top_av_reg  <= top_avail;
                left_av_reg <= left_avail;
                row_reg     <= '0;
                busy        <= 1'b1;
                for (int i = 0; i < 16; i++) begin
                    top_reg[i]  <= toppixels[i*PIXW +: PIXW];
                    left_reg[i] <= leftpixels[i*PIXW +: PIXW];
                end
            end
            if (state_reg == DCCALC) dc_reg <= dc_next;
            // A new accept overrides the retire so continuous flow has no bubble.
            if (res_fire) begin
                rec_row             <= rec_pix;
                rec_idx             <= row_reg;
                rec_last            <= (row_reg == 4'd15);
                rec_valid           <= 1'b1;
                shadow_reg[row_reg] <= rec_pix[15*PIXW +: PIXW];
                row_reg             <= row_reg + 4'd1;
            end else if (rec_fire) begin
                rec_valid <= 1'b0;
                rec_last  <= 1'b0;
            end
            // Neighbour outputs only move once the whole block has left.
            if (state_reg == FLUSH && rec_fire) begin
                new_top <= rec_row;
                for (int i = 0; i < 16; i++) new_left[i*PIXW +: PIXW] <= shadow_reg[i];
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule
